// File: rtl/shift_register_sequencer_pkg.sv
// ---- shift_reg_pkg : op and FSM state encodings shared by the sequencer and its benches (rev 1.0) ----
`default_nettype none

package shift_reg_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_RIGHT = 2'b01,
    OP_LEFT  = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_register_sequencer_if.sv
// ---- shift_register_sequencer_if : command handshake bus into the sequencer (rev 1.0) ----
`default_nettype none

interface shift_register_sequencer_if #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 4
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [COUNT_WIDTH-1:0] cmd_count;
  logic [WIDTH-1:0]       cmd_bits;
  logic [WIDTH-1:0]       cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_bits, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_bits, cmd_data,
    output cmd_ready
  );

endinterface

`default_nettype wire

// File: rtl/shift_register_sequencer.sv
// ---- shift_register_sequencer : turns one command into a run of control cycles for a
// ---- universal shift register (hold / shift right / shift left / parallel load) (rev 1.0) ----
`default_nettype none

module shift_register_sequencer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  shift_register_sequencer_if.slave cmd,
  input  wire logic               abort,
  output logic                    sr_enable,
  output logic [1:0]              sr_direction,
  output logic                    sr_serial_in_left,
  output logic                    sr_serial_in_right,
  output logic [WIDTH-1:0]        sr_parallel_in,
  output logic                    sr_load,
  output logic                    busy,
  output logic                    done
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = '0;

  state_e                 state;
  state_e                 next_state;
  op_e                    lat_op;
  logic [COUNT_WIDTH-1:0] lat_count;
  logic [WIDTH-1:0]       bit_buf;
  logic [WIDTH-1:0]       lat_data;
  logic [COUNT_WIDTH-1:0] eff_count;
  logic                   accept;

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state == ST_IDLE);
  // A load always occupies exactly one RUN cycle regardless of the count field.
  assign eff_count     = (op_e'(cmd.cmd_op) == OP_LOAD) ? COUNT_ONE : cmd.cmd_count;

  assign sr_parallel_in = lat_data;
  assign busy           = (state == ST_RUN) || (state == ST_DONE);
  assign done           = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_op    <= OP_HOLD;
      lat_count <= '0;
      bit_buf   <= '0;
      lat_data  <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_op    <= op_e'(cmd.cmd_op);
        lat_count <= eff_count;
        bit_buf   <= cmd.cmd_bits;
        lat_data  <= cmd.cmd_data;
      end else if (state == ST_RUN) begin
        lat_count <= lat_count - COUNT_ONE;
        bit_buf   <= bit_buf >> 1;
      end
    end
  end

  always_comb begin
    next_state         = state;
    sr_enable          = 1'b0;
    sr_direction       = 2'b00;
    sr_serial_in_left  = 1'b0;
    sr_serial_in_right = 1'b0;
    sr_load            = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          next_state = (eff_count == COUNT_ZERO) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        sr_enable    = 1'b1;
        sr_direction = lat_op;
        unique case (lat_op)
          OP_RIGHT: sr_serial_in_left  = bit_buf[0];
          OP_LEFT:  sr_serial_in_right = bit_buf[0];
          OP_LOAD:  sr_load            = 1'b1;
          default:  ;
        endcase
        // The abort cycle still drives its shift; only the transition changes.
        if (abort) begin
          next_state = ST_IDLE;
        end else if (lat_count == COUNT_ONE) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_register_sequencer.sv
// ---- tb_shift_register_sequencer : directed bench with a behavioural downstream shift register
// ---- and a queue of expected command outcomes (rev 1.0) ----
`default_nettype none

module tb_shift_register_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       sr_enable;
  logic [1:0] sr_direction;
  logic       sr_serial_in_left;
  logic       sr_serial_in_right;
  logic [7:0] sr_parallel_in;
  logic       sr_load;
  logic       busy;
  logic       done;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sr_reg;

  typedef struct {
    logic [7:0] reg_val;
    int         enables;
    int         loads;
    int         latency;
    bit         expect_done;
    logic [7:0] pin;
  } exp_t;

  exp_t sb[$];

  shift_register_sequencer_if #(.WIDTH(8), .COUNT_WIDTH(4)) cmd_bus ();

  shift_register_sequencer #(.WIDTH(8), .COUNT_WIDTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd                (cmd_bus),
    .abort              (abort),
    .sr_enable          (sr_enable),
    .sr_direction       (sr_direction),
    .sr_serial_in_left  (sr_serial_in_left),
    .sr_serial_in_right (sr_serial_in_right),
    .sr_parallel_in     (sr_parallel_in),
    .sr_load            (sr_load),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream universal shift register, sharing the sequencer reset.
  always @(posedge clk) begin
    if (rst) begin
      sr_reg <= 8'h00;
    end else if (sr_enable) begin
      if (sr_load) begin
        sr_reg <= sr_parallel_in;
      end else begin
        case (sr_direction)
          2'b01:   sr_reg <= {sr_serial_in_left, sr_reg[7:1]};
          2'b10:   sr_reg <= {sr_reg[6:0], sr_serial_in_right};
          default: sr_reg <= sr_reg;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, cmd_bus.cmd_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_sr_ctrl"}, {26'd0, sr_enable, sr_load, sr_serial_in_left,
                              sr_serial_in_right, sr_direction}, 32'd0);
  endtask

  // abort_at > 0 : raise abort in that RUN cycle; abort_at < 0 : raise abort at acceptance (IDLE).
  task automatic issue(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] bits,
                       input logic [7:0] data, input exp_t e, input int abort_at,
                       input bit keep_valid);
    int   t_acc;
    int   en_cnt;
    int   ld_cnt;
    int   bad;
    int   run_idx;
    int   lat;
    bit   saw_done;
    bit   finished;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_count = cnt;
    cmd_bus.cmd_bits  = bits;
    cmd_bus.cmd_data  = data;
    abort             = (abort_at < 0);
    @(posedge clk);
    #1;
    t_acc = cyc;
    if (keep_valid) begin
      cmd_bus.cmd_op   = 2'b11;
      cmd_bus.cmd_data = 8'hEE;
    end else begin
      cmd_bus.cmd_valid = 1'b0;
    end
    en_cnt = 0; ld_cnt = 0; bad = 0; run_idx = 0; lat = -1;
    saw_done = 1'b0; finished = 1'b0;
    for (int budget = 0; budget < 40 && !finished; budget++) begin
      @(negedge clk);
      abort = 1'b0;
      if (done) begin
        saw_done = 1'b1;
        lat      = cyc - t_acc;
        finished = 1'b1;
        if (sr_enable || sr_load || sr_serial_in_left || sr_serial_in_right || sr_direction != 2'b00)
          bad++;
      end else if (cmd_bus.cmd_ready) begin
        finished = 1'b1;
      end else if (sr_enable) begin
        en_cnt++;
        run_idx++;
        if (sr_load) ld_cnt++;
        if (sr_direction != op) bad++;
        if (op != 2'b01 && sr_serial_in_left) bad++;
        if (op != 2'b10 && sr_serial_in_right) bad++;
        if (run_idx == abort_at) abort = 1'b1;
      end else begin
        bad++;
      end
    end
    cmd_bus.cmd_valid = 1'b0;
    check("cmd_finished_in_budget", {31'd0, finished}, 32'd1);
    x = sb.pop_front();
    check("sr_register", {24'd0, sr_reg}, {24'd0, x.reg_val});
    check("enable_cycles", en_cnt, x.enables);
    check("load_cycles", ld_cnt, x.loads);
    check("done_seen", {31'd0, saw_done}, {31'd0, x.expect_done});
    check("done_latency", lat, x.latency);
    check("run_outputs_ok", bad, 0);
    check("parallel_in", {24'd0, sr_parallel_in}, {24'd0, x.pin});
    if (saw_done) @(negedge clk);
    check_idle_outputs("after_cmd");
  endtask

  initial begin
    bit saw_done_rst;
    rst               = 1'b1;
    abort             = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'b00;
    cmd_bus.cmd_count = 4'd0;
    cmd_bus.cmd_bits  = 8'h00;
    cmd_bus.cmd_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_parallel_in", {24'd0, sr_parallel_in}, 32'd0);
    rst = 1'b0;

    // shift right 3 of 0b101 into 0x00
    issue(2'b01, 4'd3, 8'h05, 8'h00, '{8'hA0, 3, 0, 3, 1'b1, 8'h00}, 0, 1'b0);
    // parallel load, count field ignored; abort raised at acceptance must be ignored
    issue(2'b11, 4'd7, 8'h00, 8'h5A, '{8'h5A, 1, 1, 1, 1'b1, 8'h5A}, -1, 1'b0);
    // zero-count shift left: straight to DONE
    issue(2'b10, 4'd0, 8'hFF, 8'h11, '{8'h5A, 0, 0, 0, 1'b1, 8'h11}, 0, 1'b0);
    // hold 4 cycles while cmd_valid stays high with a different load
    issue(2'b00, 4'd4, 8'hFF, 8'h77, '{8'h5A, 4, 0, 4, 1'b1, 8'h77}, 0, 1'b1);
    // load with count 0 still performs one load
    issue(2'b11, 4'd0, 8'h00, 8'h01, '{8'h01, 1, 1, 1, 1'b1, 8'h01}, 0, 1'b0);
    // abort on 2nd RUN cycle of a left shift
    issue(2'b10, 4'd5, 8'h00, 8'h00, '{8'h04, 2, 0, -1, 1'b0, 8'h00}, 2, 1'b0);
    // count beyond WIDTH injects zeros after the eighth bit
    issue(2'b11, 4'd1, 8'h00, 8'h00, '{8'h00, 1, 1, 1, 1'b1, 8'h00}, 0, 1'b0);
    issue(2'b10, 4'd10, 8'hFF, 8'h00, '{8'hFC, 10, 0, 10, 1'b1, 8'h00}, 0, 1'b0);
    issue(2'b01, 4'd15, 8'hFF, 8'h00, '{8'h01, 15, 0, 15, 1'b1, 8'h00}, 0, 1'b0);

    // reset in the middle of a RUN after three shifts
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = 2'b01;
    cmd_bus.cmd_count = 4'd8;
    cmd_bus.cmd_bits  = 8'hAA;
    cmd_bus.cmd_data  = 8'h99;
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid = 1'b0;
    saw_done_rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done_rst = 1'b1;
    end
    check("rst_mid_run_enable", {31'd0, sr_enable}, 32'd1);
    rst   = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    if (done) saw_done_rst = 1'b1;
    rst   = 1'b0;
    abort = 1'b0;
    check_idle_outputs("rst_mid_run");
    check("rst_mid_run_parallel_in", {24'd0, sr_parallel_in}, 32'd0);
    check("rst_mid_run_no_done", {31'd0, saw_done_rst}, 32'd0);
    issue(2'b11, 4'd3, 8'h00, 8'h3C, '{8'h3C, 1, 1, 1, 1'b1, 8'h3C}, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
